// File: rtl/conv2_win_buf.sv
// conv2_win_buf: raster-order line buffer for a three-channel feature map.
// Each channel shifts pixels into a (FILTER_SIZE-1)*WIDTH+FILTER_SIZE deep
// register chain. The FILTER_SIZE x FILTER_SIZE window is tapped from that
// chain and registered on every accepted pixel. A row/column tracker marks
// the positions where the whole window lies inside the current frame, and a
// one-cycle strobe flags each such window.
module conv2_win_buf #(
  parameter int WIDTH       = 12,
  parameter int DATA_BITS   = 12,
  parameter int FILTER_SIZE = 5
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           valid_in,
  input  logic signed [DATA_BITS-1:0]                    data_in1,
  input  logic signed [DATA_BITS-1:0]                    data_in2,
  input  logic signed [DATA_BITS-1:0]                    data_in3,
  output logic        [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out1,
  output logic        [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out2,
  output logic        [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out3,
  output logic                                           valid_out_buf
);

  localparam int NCH   = 3;
  localparam int DEPTH = (FILTER_SIZE - 1) * WIDTH + FILTER_SIZE;
  localparam int NWIN  = FILTER_SIZE * FILTER_SIZE;
  localparam int WBITS = NWIN * DATA_BITS;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] LAST_POS = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FIRST_WIN = CW'(FILTER_SIZE - 1);

  // Channel inputs gathered so every channel shares one code path.
  logic signed [DATA_BITS-1:0] din [NCH];

  assign din[0] = data_in1;
  assign din[1] = data_in2;
  assign din[2] = data_in3;

  // Index 0 holds the newest pixel; index DEPTH-1 the oldest still needed.
  logic signed [DATA_BITS-1:0] sr_q [NCH][DEPTH];
  logic signed [DATA_BITS-1:0] sr_d [NCH][DEPTH];

  logic [WBITS-1:0] win_q [NCH];
  logic [WBITS-1:0] win_d [NCH];

  // Position (row, col) of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;

  logic vld_q, vld_d;
  logic in_win;
  logic last_col;
  logic last_row;

  // Shift chain: every channel advances one slot per accepted pixel.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      sr_d[ch][0] = valid_in ? din[ch] : sr_q[ch][0];
      for (int i = 1; i < DEPTH; i++) begin
        sr_d[ch][i] = valid_in ? sr_q[ch][i-1] : sr_q[ch][i];
      end
    end
  end

  // Window taps: element r*F+c is the pixel (F-1-r) rows and (F-1-c)
  // columns behind the newest one, taken from the post-shift chain so the
  // registered window already includes the pixel accepted on this edge.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      win_d[ch] = win_q[ch];
      if (valid_in) begin
        for (int r = 0; r < FILTER_SIZE; r++) begin
          for (int c = 0; c < FILTER_SIZE; c++) begin
            win_d[ch][DATA_BITS*(r*FILTER_SIZE+c) +: DATA_BITS] =
              sr_d[ch][(FILTER_SIZE-1-r)*WIDTH + (FILTER_SIZE-1-c)];
          end
        end
      end
    end
  end

  // Raster position tracker; wraps at row and frame ends without touching
  // the pixel chain, so the next frame streams straight in.
  always_comb begin
    last_col = (col_q == LAST_POS);
    last_row = (row_q == LAST_POS);
    col_d    = col_q;
    row_d    = row_q;
    if (valid_in) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Window-complete strobe: the accepted pixel closes a window that lies
  // entirely inside one frame and does not straddle a row edge.
  always_comb begin
    in_win = (row_q >= FIRST_WIN) && (col_q >= FIRST_WIN);
    vld_d  = valid_in && in_win;
  end

  // State update; reset clears position, strobe, chain and window outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      vld_q <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        win_q[ch] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          sr_q[ch][i] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= vld_d;
      for (int ch = 0; ch < NCH; ch++) begin
        win_q[ch] <= win_d[ch];
        for (int i = 0; i < DEPTH; i++) begin
          sr_q[ch][i] <= sr_d[ch][i];
        end
      end
    end
  end

  assign data_out1     = win_q[0];
  assign data_out2     = win_q[1];
  assign data_out3     = win_q[2];
  assign valid_out_buf = vld_q;

endmodule

// File: tb/tb_conv2_win_buf.sv
// tb_conv2_win_buf: directed bench for conv2_win_buf at default parameters.
module tb_conv2_win_buf;

  localparam int W  = 12;
  localparam int DB = 12;
  localparam int WB = 25 * DB;

  logic               clk;
  logic               rst_n;
  logic               valid_in;
  logic signed [DB-1:0] data_in1, data_in2, data_in3;
  logic [WB-1:0]      data_out1, data_out2, data_out3;
  logic               valid_out_buf;

  int n_chk;
  int n_fail;
  int cur_p;

  conv2_win_buf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in1     (data_in1),
    .data_in2     (data_in2),
    .data_in3     (data_in3),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .data_out3    (data_out3),
    .valid_out_buf(valid_out_buf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int e0;
    int e4;
    int e20;
    int e24;
    int c2_24;
    int c3_24;
  } vec_t;

  vec_t tbl [6];

  function automatic int el(input logic [WB-1:0] bus, input int k);
    logic signed [DB-1:0] v;
    v = bus[DB*k +: DB];
    return int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (pixel %0d): got %0d, expected %0d", nm, cur_p, act, exp);
    end
  endtask

  task automatic push(input logic v, input int a, input int b, input int c);
    valid_in = v;
    data_in1 = DB'(a);
    data_in2 = DB'(b);
    data_in3 = DB'(c);
    @(posedge clk);
    #1;
  endtask

  // Pixel p of a frame: ch1 = base+p, ch2 = base+p+256, ch3 = -(base+p).
  task automatic run_frame(input int base, input bit gaps);
    int pulses;
    int exp_pulse;
    logic [WB-1:0] prev;
    pulses = 0;
    for (int p = 0; p < 144; p++) begin
      cur_p = p;
      if (gaps) begin
        prev = data_out1;
        push(1'b0, 0, 0, 0);
        chk("gap_valid", int'(valid_out_buf), 0);
        chk("gap_hold_e24", el(data_out1, 24), el(prev, 24));
        chk("gap_hold_e0", el(data_out1, 0), el(prev, 0));
      end
      push(1'b1, base + p, base + p + 256, -(base + p));
      exp_pulse = ((p / W) >= 4 && (p % W) >= 4) ? 1 : 0;
      chk("pulse", int'(valid_out_buf), exp_pulse);
      if (valid_out_buf) pulses++;
      for (int t = 0; t < 6; t++) begin
        if (tbl[t].idx == p) begin
          chk("ch1_e0",  el(data_out1, 0),  base + tbl[t].e0);
          chk("ch1_e4",  el(data_out1, 4),  base + tbl[t].e4);
          chk("ch1_e20", el(data_out1, 20), base + tbl[t].e20);
          chk("ch1_e24", el(data_out1, 24), base + tbl[t].e24);
          chk("ch2_e24", el(data_out2, 24), base + tbl[t].c2_24);
          chk("ch3_e24", el(data_out3, 24), tbl[t].c3_24 - base);
        end
      end
    end
    valid_in = 1'b0;
    cur_p = -1;
    chk("pulse_count", pulses, 64);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cur_p  = -1;

    // idx, e0, e4, e20, e24, ch2 e24, ch3 e24 (for base 0)
    tbl[0] = '{52,   0,  4,  48,  52, 308,  -52};
    tbl[1] = '{53,   1,  5,  49,  53, 309,  -53};
    tbl[2] = '{59,   7, 11,  55,  59, 315,  -59};
    tbl[3] = '{64,  12, 16,  60,  64, 320,  -64};
    tbl[4] = '{100, 48, 52,  96, 100, 356, -100};
    tbl[5] = '{143, 91, 95, 139, 143, 399, -143};

    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in1 = '0;
    data_in2 = '0;
    data_in3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid_out_buf), 0);
    chk("rst_out1", int'(|data_out1), 0);
    chk("rst_out2", int'(|data_out2), 0);
    chk("rst_out3", int'(|data_out3), 0);
    rst_n = 1'b1;
    push(1'b0, 0, 0, 0);
    chk("idle_valid", int'(valid_out_buf), 0);

    // Continuous frame, then the same frame with idle gaps, then a
    // back-to-back frame with offset values.
    run_frame(0, 1'b0);
    run_frame(0, 1'b1);
    run_frame(1000, 1'b0);

    // Mid-frame reset: 71 pixels, then reset held with valid_in high.
    for (int p = 0; p <= 70; p++) push(1'b1, p, p + 256, -p);
    rst_n = 1'b0;
    push(1'b1, 71, 71 + 256, -71);
    rst_n = 1'b1;
    valid_in = 1'b0;
    cur_p = -1;
    chk("mid_rst_valid", int'(valid_out_buf), 0);
    chk("mid_rst_out1", int'(|data_out1), 0);
    chk("mid_rst_out2", int'(|data_out2), 0);
    chk("mid_rst_out3", int'(|data_out3), 0);
    push(1'b0, 0, 0, 0);
    chk("mid_rst_idle_out1", int'(|data_out1), 0);
    run_frame(500, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
